maxnet_controller: RTL and testbench

Sequencing FSM for the 4-neuron Maxnet winner-take-all datapath. On a `start` request it loads the four input numbers, then runs activate → multiply → accumulate → check iterations until the datapath raises `found`. It drives all datapath write enables and feedback mux selects, and reports completion with a one-cycle `done` pulse. It sits between the top-level host handshake and the datapath.

---
 rtl/maxnet_controller.sv | 140 ++++++++++++++
 tb/tb_maxnet_controller.sv | 130 +++++++++++++
 2 files changed

// File: rtl/maxnet_controller.sv
// Sequencing FSM for the 4-neuron Maxnet winner-take-all datapath.
// Optional iteration limit compiled in with `define MAXNET_TIMEOUT_EN.
module maxnet_controller #(
  parameter int MAX_ITER = 64,
  parameter int ITER_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              found,
  output logic              mainRegWrite,
  output logic              actWrite,
  output logic              multWrite,
  output logic              addWrite,
  output logic              s1,
  output logic              s2,
  output logic              s3,
  output logic              s4,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [ITER_W-1:0] iter_count
);

  // state   | meaning
  // S_IDLE  | waiting for start, datapath frozen
  // S_LOAD  | load num1..num4 into main registers
  // S_ACT   | load activation registers (x first pass, b afterwards)
  // S_MULT  | load PU product registers
  // S_ADD   | load f_reg (b) registers
  // S_CHECK | evaluate found / iteration limit
  // S_DONE  | one-cycle completion pulse
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ACT, S_MULT, S_ADD, S_CHECK, S_DONE
  } state_t;

`ifdef MAXNET_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam logic [ITER_W-1:0] LIMIT = ITER_W'(MAX_ITER - 1);

  state_t            state_q;
  logic              main_wr_q, act_wr_q, mult_wr_q, add_wr_q;
  logic              sel_q, busy_q, done_q, timeout_q;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              limit_hit;

  // Saturating increment; with the limit compiled in the count never reaches all-ones.
  assign iter_d    = (iter_q == '1) ? iter_q : iter_q + ITER_W'(1);
  assign limit_hit = TIMEOUT_EN && (iter_q == LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      main_wr_q <= 1'b0;
      act_wr_q  <= 1'b0;
      mult_wr_q <= 1'b0;
      add_wr_q  <= 1'b0;
      sel_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      iter_q    <= '0;
    end else begin
      main_wr_q <= 1'b0;
      act_wr_q  <= 1'b0;
      mult_wr_q <= 1'b0;
      add_wr_q  <= 1'b0;
      sel_q     <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_LOAD;
            main_wr_q <= 1'b1;
            busy_q    <= 1'b1;
            iter_q    <= '0;
            timeout_q <= 1'b0;
          end
        end
        S_LOAD: begin
          state_q  <= S_ACT;
          act_wr_q <= 1'b1;
          sel_q    <= 1'b0;
        end
        S_ACT: begin
          state_q   <= S_MULT;
          mult_wr_q <= 1'b1;
        end
        S_MULT: begin
          state_q  <= S_ADD;
          add_wr_q <= 1'b1;
        end
        S_ADD: begin
          state_q <= S_CHECK;
        end
        S_CHECK: begin
          iter_q <= iter_d;
          if (found) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else if (limit_hit) begin
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end else begin
            state_q  <= S_ACT;
            act_wr_q <= 1'b1;
            sel_q    <= (iter_d != '0);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mainRegWrite = main_wr_q;
  assign actWrite     = act_wr_q;
  assign multWrite    = mult_wr_q;
  assign addWrite     = add_wr_q;
  assign s1           = sel_q;
  assign s2           = sel_q;
  assign s3           = sel_q;
  assign s4           = sel_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign timeout      = timeout_q;
  assign iter_count   = iter_q;

endmodule

// File: tb/tb_maxnet_controller.sv
// Self-checking bench for maxnet_controller: per-cycle expected output vectors
// are queued when a run is launched and popped as each cycle is observed.
module tb_maxnet_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       found = 1'b0;
  logic       mainRegWrite, actWrite, multWrite, addWrite;
  logic       s1, s2, s3, s4, busy, done, timeout;
  logic [7:0] iter_count;

  int n_checks = 0;
  int n_errors = 0;
  logic [18:0] exp_q[$];

  maxnet_controller #(.MAX_ITER(4), .ITER_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .found(found),
    .mainRegWrite(mainRegWrite), .actWrite(actWrite),
    .multWrite(multWrite), .addWrite(addWrite),
    .s1(s1), .s2(s2), .s3(s3), .s4(s4),
    .busy(busy), .done(done), .timeout(timeout), .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // {iter_count, timeout, main, act, mult, add, s1..s4, busy, done}
  function automatic logic [18:0] obs(input logic sel_en);
    return {iter_count, timeout, mainRegWrite, actWrite, multWrite, addWrite,
            {s1, s2, s3, s4} & {4{sel_en}}, busy, done};
  endfunction

  // Expected outputs in cycle c of an n-iteration run (LOAD is cycle 1).
  function automatic logic [18:0] exp_vec(input int c, input int n, input logic to);
    logic       main_e, act_e, mult_e, add_e, busy_e, done_e, to_e;
    logic [3:0] sel_e;
    int         it;
    main_e = (c == 1);
    act_e = 1'b0; mult_e = 1'b0; add_e = 1'b0; sel_e = 4'h0;
    if (c >= 2 && c <= 1 + 4*n) begin
      case ((c - 2) % 4)
        0: begin act_e = 1'b1; sel_e = ((c - 2) / 4 > 0) ? 4'hF : 4'h0; end
        1: mult_e = 1'b1;
        2: add_e = 1'b1;
        default: ;
      endcase
    end
    busy_e = (c >= 1 && c <= 2 + 4*n);
    done_e = (c == 2 + 4*n);
    to_e   = (c >= 2 + 4*n) ? to : 1'b0;
    it     = (c < 2) ? 0 : (((c - 2) / 4 < n) ? (c - 2) / 4 : n);
    return {8'(it), to_e, main_e, act_e, mult_e, add_e, sel_e, busy_e, done_e};
  endfunction

  function automatic logic found_for(input int c, input int f_from, input bit stale);
    return (stale && c <= 3) || (c >= f_from);
  endfunction

  task automatic run(input string tag, input int n, input logic to, input int f_from,
                     input bit stale, input bit busy_pulse, input bit hold_next, input int max_c);
    int last;
    last = (3 + 4*n < max_c) ? 3 + 4*n : max_c;
    for (int c = 1; c <= last; c++) exp_q.push_back(exp_vec(c, n, to));
    start = 1'b1;
    found = found_for(0, f_from, stale);
    for (int c = 1; c <= last; c++) begin
      logic [18:0] e;
      @(posedge clk); #1;
      e = exp_q.pop_front();
      check_eq($sformatf("%s c%0d", tag, c), 32'(obs(e[8])), 32'(e));
      start = (busy_pulse && c + 1 == 5) || (hold_next && c + 1 >= 2 + 4*n);
      found = found_for(c + 1, f_from, stale);
    end
  endtask

  // Called at posedge+1; asserts reset mid-cycle and checks the immediate effect.
  task automatic do_reset(input string tag);
    #2 rst = 1'b0;
    #1 check_eq({tag, " async"}, 32'(obs(1'b1)), 32'h0);
    #3 rst = 1'b1;
    start = 1'b0;
    found = 1'b0;
    @(posedge clk); #1;
    check_eq({tag, " idle"}, 32'(obs(1'b1)), 32'h0);
  endtask

  initial begin
    #1 rst = 1'b0;
    #2 check_eq("reset", 32'(obs(1'b1)), 32'h0);
    #9 rst = 1'b1;
    @(posedge clk); #1;
    check_eq("idle_after_reset", 32'(obs(1'b1)), 32'h0);

    run("single", 1, 1'b0, 5, 1'b0, 1'b0, 1'b0, 99);
    run("three", 3, 1'b0, 13, 1'b0, 1'b0, 1'b0, 99);
    run("busy_start", 2, 1'b0, 9, 1'b0, 1'b1, 1'b1, 99);
    run("chained", 1, 1'b0, 5, 1'b0, 1'b0, 1'b0, 99);
    run("stale", 2, 1'b0, 9, 1'b1, 1'b0, 1'b0, 99);
`ifdef MAXNET_TIMEOUT_EN
    run("timeout", 4, 1'b1, 100000, 1'b0, 1'b0, 1'b0, 99);
    run("after_timeout", 1, 1'b0, 5, 1'b0, 1'b0, 1'b0, 99);
`else
    run("no_winner", 100, 1'b0, 100000, 1'b0, 1'b0, 1'b0, 30);
    do_reset("no_winner_rst");
`endif
    run("rst_mid", 1, 1'b0, 5, 1'b0, 1'b0, 1'b0, 3);
    do_reset("rst_mid");
    run("recover", 2, 1'b0, 9, 1'b0, 1'b0, 1'b0, 99);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
